// File: rtl/video_stream_scheduler.sv
// Sequences flash read start/end pulses, gates read_enable with a credit count
// over the instruction buffer chain, and paces streaming to vertical sync.
module video_stream_scheduler #(
  parameter int DEPTH         = 4,
  parameter int HEADROOM      = 1,
  parameter int PRIME_TIMEOUT = 1024,
  parameter int FRAME_W       = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       vsync_start,
  input  logic                       instr_valid,
  input  logic                       instr_consume,
  input  logic                       eof_marker,
  input  logic                       eov_marker,
  output logic                       start_sequence,
  output logic                       end_sequence,
  output logic                       read_enable,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [FRAME_W-1:0]         frame_count,
  output logic                       streaming,
  output logic                       underrun,
  output logic                       fault
);

  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int TMR_W = $clog2(PRIME_TIMEOUT+1);
  localparam logic [OCC_W-1:0] FULL      = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] LOW_WATER = OCC_W'(DEPTH-HEADROOM);
  localparam logic [TMR_W-1:0] TIMEOUT   = TMR_W'(PRIME_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_PRIME, S_WAIT_VS, S_STREAM, S_RESTART
  } state_t;

  state_t           state, state_next;
  logic             armed;
  logic [TMR_W-1:0] timer, timer_next;
  logic [OCC_W-1:0] occ_next;
  logic             re_next;
  logic             frame_done;
  logic             fault_set;
  logic             underrun_set;

  always_comb begin
    occ_next     = occupancy;
    state_next   = state;
    timer_next   = timer;
    fault_set    = 1'b0;
    underrun_set = (state == S_STREAM) && instr_consume && (occupancy == '0);
    frame_done   = (state == S_STREAM) && instr_consume && (eof_marker || eov_marker);

    // A restart flushes the chain, so in-flight traffic that cycle is dropped.
    if (state == S_RESTART) begin
      occ_next = '0;
    end else if (instr_valid && !instr_consume && occupancy != FULL) begin
      occ_next = occupancy + 1'b1;
    end else if (!instr_valid && instr_consume && occupancy != '0) begin
      occ_next = occupancy - 1'b1;
    end

    case (state)
      S_IDLE:    if (armed) state_next = S_START;
      S_START: begin
        timer_next = '0;
        state_next = S_PRIME;
      end
      S_PRIME: begin
        if (occupancy >= LOW_WATER) begin
          state_next = S_WAIT_VS;
        end else if (timer == TIMEOUT) begin
          fault_set  = 1'b1;
          state_next = S_RESTART;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      S_WAIT_VS: if (vsync_start) state_next = S_STREAM;
      S_STREAM: begin
        if (instr_consume && eov_marker)      state_next = S_RESTART;
        else if (instr_consume && eof_marker) state_next = S_WAIT_VS;
      end
      S_RESTART: state_next = S_START;
      default:   state_next = S_IDLE;
    endcase

    re_next = ((state_next == S_PRIME) || (state_next == S_STREAM)) && (occ_next < LOW_WATER);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      armed       <= 1'b0;
      timer       <= '0;
      occupancy   <= '0;
      read_enable <= 1'b0;
      frame_count <= '0;
      underrun    <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_next;
      armed       <= 1'b1;
      timer       <= timer_next;
      occupancy   <= occ_next;
      read_enable <= re_next;
      if (frame_done)   frame_count <= frame_count + 1'b1;
      if (underrun_set) underrun    <= 1'b1;
      if (fault_set)    fault       <= 1'b1;
    end
  end

  assign start_sequence = (state == S_START);
  assign end_sequence   = (state == S_RESTART);
  assign streaming      = (state == S_STREAM);

endmodule

// File: tb/tb_video_stream_scheduler.sv
// Bench for video_stream_scheduler: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the scheduler rules.
module tb_video_stream_scheduler;

  localparam int DEPTH = 4;
  localparam int HEADROOM = 1;
  localparam int PRIME_TIMEOUT = 1024;
  localparam int FRAME_W = 12;
  localparam int LOW = DEPTH - HEADROOM;

  localparam int P_IDLE = 0, P_START = 1, P_PRIME = 2, P_WAIT = 3, P_STREAM = 4, P_RESTART = 5;

  logic clk = 1'b0;
  logic rst_n, vsync_start, instr_valid, instr_consume, eof_marker, eov_marker;
  logic start_sequence, end_sequence, read_enable, streaming, underrun, fault;
  logic [$clog2(DEPTH+1)-1:0] occupancy;
  logic [FRAME_W-1:0] frame_count;

  video_stream_scheduler #(
    .DEPTH(DEPTH), .HEADROOM(HEADROOM), .PRIME_TIMEOUT(PRIME_TIMEOUT), .FRAME_W(FRAME_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vsync_start(vsync_start), .instr_valid(instr_valid),
    .instr_consume(instr_consume), .eof_marker(eof_marker), .eov_marker(eov_marker),
    .start_sequence(start_sequence), .end_sequence(end_sequence), .read_enable(read_enable),
    .occupancy(occupancy), .frame_count(frame_count), .streaming(streaming),
    .underrun(underrun), .fault(fault)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model state (values after the most recent clock edge)
  int m_phase = P_IDLE;
  bit m_armed = 0;
  int m_timer = 0;
  int m_occ = 0;
  bit m_re = 0;
  int m_frames = 0;
  bit m_under = 0;
  bit m_fault = 0;

  // flash responder: returns one instruction two cycles after each read_enable cycle
  logic re_d1 = 0, re_d2 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input bit c, input bit ef, input bit ev,
                            input bit vs);
    int occ_new;
    int ph_new;
    if (!r) begin
      m_phase = P_IDLE; m_armed = 0; m_timer = 0; m_occ = 0;
      m_re = 0; m_frames = 0; m_under = 0; m_fault = 0;
      return;
    end
    occ_new = m_occ + int'(v) - int'(c);
    if (occ_new < 0) occ_new = 0;
    if (occ_new > DEPTH) occ_new = DEPTH;
    if (m_phase == P_RESTART) occ_new = 0;
    if (m_phase == P_STREAM && c && m_occ == 0) m_under = 1;
    ph_new = m_phase;
    case (m_phase)
      P_IDLE:  if (m_armed) ph_new = P_START;
      P_START: begin m_timer = 0; ph_new = P_PRIME; end
      P_PRIME: begin
        if (m_occ >= LOW) ph_new = P_WAIT;
        else if (m_timer == PRIME_TIMEOUT) begin m_fault = 1; ph_new = P_RESTART; end
        else m_timer = m_timer + 1;
      end
      P_WAIT: if (vs) ph_new = P_STREAM;
      P_STREAM: if (c && (ev || ef)) begin
        m_frames = (m_frames + 1) % (1 << FRAME_W);
        ph_new = ev ? P_RESTART : P_WAIT;
      end
      default: ph_new = P_START;
    endcase
    m_armed = 1;
    m_phase = ph_new;
    m_occ = occ_new;
    m_re = (ph_new == P_PRIME || ph_new == P_STREAM) && (occ_new < LOW);
  endtask

  task automatic tick(input bit r, input bit v, input bit c, input bit ef, input bit ev,
                      input bit vs);
    @(negedge clk);
    rst_n = r; instr_valid = v; instr_consume = c;
    eof_marker = ef; eov_marker = ev; vsync_start = vs;
    @(posedge clk);
    model_step(r, v, c, ef, ev, vs);
    #1;
    check("start_sequence", 32'(start_sequence), 32'(m_phase == P_START));
    check("end_sequence", 32'(end_sequence), 32'(m_phase == P_RESTART));
    check("streaming", 32'(streaming), 32'(m_phase == P_STREAM));
    check("read_enable", 32'(read_enable), 32'(m_re));
    check("occupancy", 32'(occupancy), 32'(m_occ));
    check("frame_count", 32'(frame_count), 32'(m_frames));
    check("underrun", 32'(underrun), 32'(m_under));
    check("fault", 32'(fault), 32'(m_fault));
    re_d2 = r ? re_d1 : 1'b0;
    re_d1 = r ? read_enable : 1'b0;
  endtask

  // prime from reset release until WAIT_VS, then fire vsync into STREAM
  task automatic prime_to_stream();
    int n = 0;
    while (m_phase != P_WAIT && n < 200) begin
      tick(1, re_d2, 0, 0, 0, 0);
      n++;
    end
    check("prime_reaches_wait_vs_re", 32'(read_enable), 32'(0));
    tick(1, re_d2, 0, 0, 0, 1);
    check("stream_after_vsync", 32'(streaming), 32'(1));
  endtask

  initial begin
    int n;
    rst_n = 0; vsync_start = 0; instr_valid = 0; instr_consume = 0;
    eof_marker = 0; eov_marker = 0;

    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0, 0);
    check("reset_occupancy", 32'(occupancy), 32'(0));
    check("reset_read_enable", 32'(read_enable), 32'(0));

    // start_sequence on the second clock after release
    tick(1, 0, 0, 0, 0, 0);
    check("start_pre", 32'(start_sequence), 32'(0));
    tick(1, 0, 0, 0, 0, 0);
    check("start_at_2", 32'(start_sequence), 32'(1));
    tick(1, 0, 0, 0, 0, 0);
    check("start_one_cycle", 32'(start_sequence), 32'(0));

    // prime; late arrivals settle in WAIT_VS, no vsync yet
    n = 0;
    while (m_phase != P_WAIT && n < 200) begin tick(1, re_d2, 0, 0, 0, 0); n++; end
    check("wait_vs_re_low", 32'(read_enable), 32'(0));
    check("wait_vs_occ_ge_low", 32'(occupancy >= LOW), 32'(1));
    for (int i = 0; i < 5; i++) tick(1, re_d2, 0, 0, 0, 0);
    check("wait_vs_holds", 32'(streaming), 32'(0));
    tick(1, re_d2, 0, 0, 0, 1);
    check("stream_rise", 32'(streaming), 32'(1));

    // steady streaming, consume every 4th cycle, a stray vsync ignored
    for (int i = 0; i < 40; i++) tick(1, re_d2, (i % 4) == 3, 0, 0, i == 10);
    check("stream_no_underrun", 32'(underrun), 32'(0));
    check("stream_still", 32'(streaming), 32'(1));

    // end of frame
    tick(1, re_d2, 1, 1, 0, 0);
    check("eof_frame_count", 32'(frame_count), 32'(1));
    check("eof_to_wait", 32'(streaming), 32'(0));
    for (int i = 0; i < 3; i++) tick(1, re_d2, 0, 0, 0, 0);
    check("eof_wait_re", 32'(read_enable), 32'(0));
    tick(1, re_d2, 0, 0, 0, 1);
    for (int i = 0; i < 12; i++) tick(1, re_d2, (i % 4) == 3, 0, 0, 0);

    // both markers: end of video wins
    tick(1, re_d2, 1, 1, 1, 0);
    check("eov_frame_count", 32'(frame_count), 32'(2));
    check("eov_end_sequence", 32'(end_sequence), 32'(1));
    tick(1, re_d2, 0, 0, 0, 0);
    check("eov_occ_flushed", 32'(occupancy), 32'(0));
    check("eov_restart", 32'(start_sequence), 32'(1));

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick(1, re_d2 | ($urandom_range(0, 29) == 0), $urandom_range(0, 3) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0, $urandom_range(0, 9) == 0);
    end

    // same-cycle valid/consume at occupancy 2, then underrun at empty
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    prime_to_stream();
    n = 0;
    while (m_occ != 2 && n < 10) begin tick(1, 0, m_occ > 2, 0, 0, 0); n++; end
    tick(1, 1, 1, 0, 0, 0);
    check("valid_consume_same_cycle", 32'(occupancy), 32'(2));
    n = 0;
    while (m_occ != 0 && n < 10) begin tick(1, 0, 1, 0, 0, 0); n++; end
    check("underrun_not_yet", 32'(underrun), 32'(0));
    tick(1, 0, 1, 0, 0, 0);
    check("underrun_set", 32'(underrun), 32'(1));
    check("underrun_occ_zero", 32'(occupancy), 32'(0));

    // reset mid-stream
    tick(0, 1, 1, 0, 0, 0);
    check("midreset_streaming", 32'(streaming), 32'(0));
    check("midreset_underrun", 32'(underrun), 32'(0));
    check("midreset_end_sequence", 32'(end_sequence), 32'(0));
    tick(0, 0, 0, 0, 0, 0);

    // prime timeout with no instructions ever arriving
    n = 0;
    while (start_sequence !== 1'b1 && n < 10) begin tick(1, 0, 0, 0, 0, 0); n++; end
    check("timeout_start_seen", 32'(start_sequence), 32'(1));
    n = 0;
    while (fault !== 1'b1 && n < PRIME_TIMEOUT + 20) begin tick(1, 0, 0, 0, 0, 0); n++; end
    check("timeout_cycle", 32'(n), 32'(PRIME_TIMEOUT + 2));
    check("timeout_end_sequence", 32'(end_sequence), 32'(1));
    tick(1, 0, 0, 0, 0, 0);
    check("timeout_restart", 32'(start_sequence), 32'(1));
    check("fault_sticky", 32'(fault), 32'(1));
    for (int i = 0; i < 5; i++) tick(1, 0, 0, 0, 0, 0);
    check("fault_still_sticky", 32'(fault), 32'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
